scope_capture: RTL and testbench
================================

# scope_capture

Trigger-and-capture stage placed directly downstream of `downsampling`, consuming its `oData`/`oData_Valid` sample stream. Once armed, it keeps a circular pre-trigger history, detects a level crossing on the configured edge, and fills a fixed post-trigger window. It then streams the frozen record, oldest sample first, over a valid/ready interface to the output/host side.

## Interface
- `DEPTH_LOG2`, 9, log2 of record length. DEPTH = 2^DEPTH_LOG2 samples.
- `PRETRIG`, 64, number of samples stored before the trigger sample. Legal range 1..DEPTH-1.

Ports:
- `iClk` in 1: sole clock, shared with `downsampling`.
- `iRst_n` in 1: asynchronous active-low reset.
- `iData` in 8: unsigned sample from `downsampling`.
- `iData_Valid` in 1: `iData` qualifier. One sample per high cycle.
- `iArm` in 1: start an acquisition. Sampled only in IDLE.
- `iLevel` in 8: trigger threshold, unsigned.
- `iRising` in 1: 1 = rising-edge trigger, 0 = falling-edge trigger.
- `oBusy` out 1: high in every state except IDLE.
- `oTriggered` out 1: one-cycle pulse when the trigger fires.
- `oRd_Data` out 8: readout sample.
- `oRd_Valid` out 1: `oRd_Data` is valid.
- `oRd_Last` out 1: marks the final sample of the record. Qualified by `oRd_Valid`.
- `iRd_Ready` in 1: consumer accepts `oRd_Data`.

## Operation
- Storage is a DEPTH x 8 single-clock RAM with synchronous read, inferable as iCE40 BRAM. RAM contents are not reset.
- The write pointer is DEPTH_LOG2 bits and wraps modulo DEPTH. Each accepted sample (`iData_Valid`=1 in PRE, WAIT or POST) is written at the write pointer, and the pointer increments.
- States:
  - IDLE: no writes. `iArm`=1 → PRE; clears the pre-count and invalidates `prev`.
  - PRE: accepts samples until PRETRIG samples are stored → WAIT. No triggering is possible in PRE.
  - WAIT: ring buffer overwrite continues. On an accepted sample that meets the trigger condition:
    - record `trig_addr` = the write pointer of that sample;
    - pulse `oTriggered`;
    - go to POST.
  - POST: accepts DEPTH-PRETRIG-1 further samples after the trigger sample → READ.
  - READ: start address is `trig_addr - PRETRIG` mod DEPTH. Streams DEPTH samples in address order, wrapping. The handshake that accepts the final sample → IDLE.
- Trigger condition (WAIT only, `prev` valid):
  - rising: `prev < iLevel` and `iData >= iLevel`;
  - falling: `prev >= iLevel` and `iData < iLevel`.
  - `prev` = last accepted sample. It is updated in PRE, WAIT and POST, and becomes valid after the first accepted sample following arm.
- Record layout: readout index PRETRIG is always the trigger sample.
- `iLevel` and `iRising` are sampled live. They must be held stable by the user while armed; no capture is made.
- `iArm` outside IDLE is ignored. `iData_Valid` in READ and IDLE is dropped; there is no backpressure toward `downsampling`.

## Timing
- Reset values: state IDLE, `oBusy`=0, `oTriggered`=0, `oRd_Valid`=0, `oRd_Last`=0, `oRd_Data`=0, all pointers and counters 0, `prev` invalid.
- Reset mid-operation returns to IDLE immediately. Any record in progress is discarded.
- `oBusy` rises the cycle after `iArm` is sampled in IDLE.
- `oTriggered` is high on the clock edge after the triggering sample is accepted, for exactly 1 cycle.
- Transition to READ occurs on the edge accepting the last POST sample.
- Readout:
  - first `oRd_Valid` no later than 2 cycles after entering READ (RAM read latency 1);
  - on a stall, `oRd_Data`, `oRd_Valid` and `oRd_Last` hold stable until `iRd_Ready`;
  - with `iRd_Ready` held high, throughput is 1 sample/cycle (read-ahead/skid register required);
  - `oRd_Valid` must not depend combinationally on `iRd_Ready`.
- After the final handshake, `oRd_Valid`=0 and `oBusy`=0 on the next cycle.
- Wrap-around: any `trig_addr` (including 0 and DEPTH-1) yields a contiguous, correctly ordered record.

## Test plan
Bench parameters: DEPTH_LOG2=4 (16), PRETRIG=4, `iRd_Ready`=1 unless stated.

- **Rising-edge ramp.** Arm, `iLevel`=0x80, rising. Feed ramp 0x70,0x71,… every cycle. → `oTriggered` one cycle after 0x80 is accepted. Readout is 0x7C..0x8B, `oRd_Last` on 0x8B, 16 valid beats.
- **Pre-count gating.** Feed 0x00,0xFF as the first 2 samples after arm with level 0x80. → no trigger inside PRE. The first crossing after 4 samples triggers, and readout index 4 equals that sample.
- **Falling edge with idle gaps.** `iRising`=0, level 0x40. Samples 0x50,0x50,0x50,0x50,0x41,0x40,0x3F arrive with `iData_Valid` every 3rd cycle. → trigger on 0x3F only; record index 4 = 0x3F.
- **Wrap.** Feed 30 samples of 0x10 in WAIT, then 0x90, then 11 samples 0x20, level 0x80. → readout is four 0x10, then 0x90, then eleven 0x20, in correct order across the address wrap.
- **Backpressure.** Toggle `iRd_Ready` randomly during READ. → no sample lost or duplicated, outputs stable while stalled, exactly one `oRd_Last`.
- **Reset and re-arm.** Assert `iRst_n`=0 during POST. → all outputs 0 immediately and `oBusy`=0. A fresh arm then produces a normal record; `iArm` pulses during READ have no effect.

Source files
------------

// File: rtl/scope_capture_if.sv
// scope_capture_if
// Bundles the sample input, arm/trigger controls and readout stream of
// scope_capture.
//   slave  modport : the capture block (consumes samples, drives readout)
//   master modport : the producer/host side
// Signals:
//   iData/iData_Valid   sample stream from downsampling, no backpressure
//   iArm/iLevel/iRising acquisition start and trigger configuration
//   oBusy/oTriggered    acquisition status
//   oRd_Data/oRd_Valid/oRd_Last/iRd_Ready  readout stream
//   dbg_state           capture FSM state (IDLE=0 PRE=1 WAIT=2 POST=3 READ=4)
//
// Readout handshake: a beat transfers on a rising clock edge where
// oRd_Valid and iRd_Ready are both high. Once oRd_Valid is raised, oRd_Data,
// oRd_Valid and oRd_Last hold until that transfer. oRd_Valid never depends
// combinationally on iRd_Ready.
interface scope_capture_if;
  logic [7:0] iData;
  logic       iData_Valid;
  logic       iArm;
  logic [7:0] iLevel;
  logic       iRising;
  logic       oBusy;
  logic       oTriggered;
  logic [7:0] oRd_Data;
  logic       oRd_Valid;
  logic       oRd_Last;
  logic       iRd_Ready;
  logic [2:0] dbg_state;

  modport slave (
    input  iData, iData_Valid, iArm, iLevel, iRising, iRd_Ready,
    output oBusy, oTriggered, oRd_Data, oRd_Valid, oRd_Last, dbg_state
  );

  modport master (
    output iData, iData_Valid, iArm, iLevel, iRising, iRd_Ready,
    input  oBusy, oTriggered, oRd_Data, oRd_Valid, oRd_Last, dbg_state
  );
endinterface

// File: rtl/scope_capture.sv
// scope_capture
// Armed trigger-and-capture stage. Keeps a PRETRIG-deep pre-trigger history
// in a circular RAM, waits for a level crossing on the selected edge, fills
// the rest of a DEPTH-sample record, then streams the frozen record oldest
// sample first.
// Ports:
//   iClk   : clock
//   iRst_n : asynchronous active-low reset
//   bus    : scope_capture_if.slave (samples, controls, readout stream)
module scope_capture #(
  parameter int DEPTH_LOG2 = 9,
  parameter int PRETRIG    = 64
) (
  input  logic            iClk,
  input  logic            iRst_n,
  scope_capture_if.slave  bus
);
  localparam int AW     = DEPTH_LOG2;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int POST_N = DEPTH - PRETRIG - 1;
  localparam logic [AW-1:0] PRE_OFF   = AW'(PRETRIG);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
  localparam logic [AW-1:0] REC_LAST  = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PRE = 3'd1, S_WAIT = 3'd2, S_POST = 3'd3, S_READ = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      ram_q;
  logic [AW-1:0]   wr_ptr, cnt, trig_addr, rd_addr, pop_cnt, start_addr;
  logic [AW:0]     issued;
  logic [7:0]      prev;
  logic            prev_valid, trig_q, rd_pend;
  logic [1:0]      occ;
  logic [7:0]      q0, q1;
  logic [2:0]      lvl;
  logic            accept, crossing, trig_hit, pre_done, post_done;
  logic            enter_read, rd_valid, pop, last_pop, issue;

  // ---------------- control decode ----------------
  assign accept    = bus.iData_Valid &&
                     (state == S_PRE || state == S_WAIT || state == S_POST);
  assign crossing  = bus.iRising ? (prev <  bus.iLevel && bus.iData >= bus.iLevel)
                                 : (prev >= bus.iLevel && bus.iData <  bus.iLevel);
  assign trig_hit  = (state == S_WAIT) && accept && prev_valid && crossing;
  assign pre_done  = (state == S_PRE)  && accept && (cnt == PRE_LAST);
  assign post_done = (state == S_POST) && accept && (cnt == POST_LAST);
  // With PRETRIG = DEPTH-1 there is no POST phase at all.
  assign enter_read = post_done || (trig_hit && (POST_N == 0));
  // Oldest sample of the record; from WAIT the trigger address is wr_ptr.
  assign start_addr = ((state == S_WAIT) ? wr_ptr : trig_addr) - PRE_OFF;

  // Readout: RAM read (1 cycle) feeds a 2-entry output FIFO. A read is
  // issued only if its data is guaranteed a FIFO slot, counting this
  // cycle's pop, so a stall never loses data and full rate is kept.
  assign rd_valid = (occ != 2'd0);
  assign pop      = rd_valid && bus.iRd_Ready;
  assign last_pop = pop && (pop_cnt == REC_LAST);
  assign lvl      = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
  assign issue    = (state == S_READ) && !issued[AW] && (lvl < 3'd2);

  // ---------------- FSM ----------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.iArm) state_nxt = S_PRE;
      S_PRE:   if (pre_done) state_nxt = S_WAIT;
      S_WAIT:  if (trig_hit) state_nxt = (POST_N == 0) ? S_READ : S_POST;
      S_POST:  if (post_done) state_nxt = S_READ;
      S_READ:  if (last_pop) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.oBusy      = (state != S_IDLE);
    bus.oTriggered = trig_q;
    bus.oRd_Valid  = rd_valid;
    bus.oRd_Data   = q0;
    bus.oRd_Last   = rd_valid && (pop_cnt == REC_LAST);
    bus.dbg_state  = state;
  end

  // ---------------- capture datapath ----------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_ptr     <= '0;
      cnt        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      trig_addr  <= '0;
      trig_q     <= 1'b0;
    end else begin
      trig_q <= trig_hit;
      if (accept) begin
        wr_ptr     <= wr_ptr + 1'b1;
        prev       <= bus.iData;
        prev_valid <= 1'b1;
      end else if (state == S_IDLE) begin
        prev_valid <= 1'b0;
      end
      if (state == S_IDLE || pre_done || post_done)
        cnt <= '0;
      else if (accept && (state == S_PRE || state == S_POST))
        cnt <= cnt + 1'b1;
      if (trig_hit) trig_addr <= wr_ptr;
    end
  end

  // ---------------- readout datapath ----------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rd_addr <= '0;
      issued  <= '0;
      pop_cnt <= '0;
      rd_pend <= 1'b0;
      occ     <= 2'd0;
      q0      <= '0;
      q1      <= '0;
    end else begin
      if (enter_read)  rd_addr <= start_addr;
      else if (issue)  rd_addr <= rd_addr + 1'b1;
      if (state == S_IDLE) issued <= '0;
      else if (issue)      issued <= issued + 1'b1;
      if (state == S_IDLE) pop_cnt <= '0;
      else if (pop)        pop_cnt <= pop_cnt + 1'b1;
      rd_pend <= issue;
      // Issue gating keeps occ + rd_pend <= 2, so a push never meets a full FIFO.
      if (pop) begin
        if (occ == 2'd2)  q0 <= q1;
        else if (rd_pend) q0 <= ram_q;
      end else if (rd_pend) begin
        if (occ == 2'd0) q0 <= ram_q;
        else             q1 <= ram_q;
      end
      occ <= occ + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  // Record RAM: no reset so it maps onto block RAM.
  always_ff @(posedge iClk) begin
    if (accept) mem[wr_ptr] <= bus.iData;
    if (issue)  ram_q <= mem[rd_addr];
  end
endmodule

// File: tb/tb_scope_capture.sv
module tb_scope_capture;
  localparam int DL = 4;
  localparam int PT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scope_capture_if bus ();
  scope_capture #(.DEPTH_LOG2(DL), .PRETRIG(PT)) dut (
    .iClk(clk), .iRst_n(rst_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];          // {last, data}
  logic [7:0] stim [64];
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    bus.iRd_Ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.iRd_Ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [8:0] e;
    logic [7:0] held_data;
    logic held_last;
    bit stall_pending = 1'b0;
    bit chk_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_idle) begin
        check("valid_after_last", bus.oRd_Valid, 0);
        check("busy_after_last", bus.oBusy, 0);
        chk_idle = 1'b0;
      end
      if (stall_pending) begin
        check("stall_valid", bus.oRd_Valid, 1);
        check("stall_data", bus.oRd_Data, held_data);
        check("stall_last", bus.oRd_Last, held_last);
        stall_pending = 1'b0;
      end
      if (bus.oRd_Valid) begin
        if (bus.iRd_Ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got data 0x%0h with no expected sample", bus.oRd_Data);
          end else begin
            e = exp_q.pop_front();
            check("rd_data", bus.oRd_Data, e[7:0]);
            check("rd_last", bus.oRd_Last, e[8]);
            if (e[8]) chk_idle = 1'b1;
          end
        end else begin
          stall_pending = 1'b1;
          held_data = bus.oRd_Data;
          held_last = bus.oRd_Last;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic arm();
    bus.iArm = 1'b1;
    @(posedge clk); #1;
    bus.iArm = 1'b0;
    check("busy_after_arm", bus.oBusy, 1);
  endtask

  task automatic feed(input logic [7:0] d, input bit exp_trig, input int gap);
    bus.iData = d;
    bus.iData_Valid = 1'b1;
    @(posedge clk); #1;
    bus.iData_Valid = 1'b0;
    check("triggered", bus.oTriggered, exp_trig);
    repeat (gap) begin
      @(posedge clk); #1;
      check("trig_in_gap", bus.oTriggered, 0);
    end
  endtask

  task automatic wait_done(input bit arm_in_read);
    int t = 0;
    while (bus.oBusy && t < 200) begin
      if (arm_in_read) bus.iArm = (t < 8) && (t % 2 == 0);
      @(posedge clk); #1;
      t++;
    end
    bus.iArm = 1'b0;
    check("done_in_time", (t < 200), 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Expected record: samples trig-PT .. trig+11, last flag on the final one.
  task automatic run_capture(input logic [7:0] level, input bit rising,
                             input int trig, input int gap, input bit arm_in_read);
    bus.iLevel  = level;
    bus.iRising = rising;
    for (int k = 0; k < 16; k++)
      exp_q.push_back({(k == 15), stim[trig - PT + k]});
    arm();
    for (int i = 0; i < trig + 12; i++)
      feed(stim[i], (i == trig), gap);
    wait_done(arm_in_read);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 28; i++) stim[i] = 8'h70 + 8'(i);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.iData = 8'h00;
    bus.iData_Valid = 1'b0;
    bus.iArm = 1'b0;
    bus.iLevel = 8'h00;
    bus.iRising = 1'b1;
    #12;
    check("rst_busy", bus.oBusy, 0);
    check("rst_trig", bus.oTriggered, 0);
    check("rst_valid", bus.oRd_Valid, 0);
    check("rst_last", bus.oRd_Last, 0);
    check("rst_data", bus.oRd_Data, 0);
    check("rst_state", bus.dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Rising-edge ramp: trigger on 0x80, record 0x7C..0x8B.
    load_ramp();
    run_capture(8'h80, 1'b1, 16, 0, 1'b0);

    // Pre-count gating: 0x00->0xFF inside PRE must not trigger.
    stim[0] = 8'h00; stim[1] = 8'hFF; stim[2] = 8'h10; stim[3] = 8'h20;
    stim[4] = 8'h30; stim[5] = 8'h90;
    for (int i = 0; i < 11; i++) stim[6 + i] = 8'h91 + 8'(i);
    run_capture(8'h80, 1'b1, 5, 0, 1'b0);

    // Falling edge, one sample every third cycle: trigger on 0x3F only.
    stim[0] = 8'h50; stim[1] = 8'h50; stim[2] = 8'h50; stim[3] = 8'h50;
    stim[4] = 8'h41; stim[5] = 8'h40; stim[6] = 8'h3F;
    for (int i = 0; i < 11; i++) stim[7 + i] = 8'h30 + 8'(i);
    run_capture(8'h40, 1'b0, 6, 2, 1'b0);

    // Wrap: 4 PRE + 30 WAIT samples of 0x10, then 0x90, then eleven 0x20.
    for (int i = 0; i < 34; i++) stim[i] = 8'h10;
    stim[34] = 8'h90;
    for (int i = 0; i < 11; i++) stim[35 + i] = 8'h20;
    run_capture(8'h80, 1'b1, 34, 0, 1'b0);

    // Backpressure: random ready during readout.
    load_ramp();
    rand_ready = 1'b1;
    run_capture(8'h80, 1'b1, 16, 0, 1'b0);
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // Reset during POST, then re-arm with iArm pulses during READ.
    load_ramp();
    bus.iLevel = 8'h80;
    bus.iRising = 1'b1;
    arm();
    for (int i = 0; i < 20; i++) feed(stim[i], (i == 16), 0);
    check("in_post_state", bus.dbg_state, 3);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.oBusy, 0);
    check("mid_rst_trig", bus.oTriggered, 0);
    check("mid_rst_valid", bus.oRd_Valid, 0);
    check("mid_rst_last", bus.oRd_Last, 0);
    check("mid_rst_data", bus.oRd_Data, 0);
    check("mid_rst_state", bus.dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_capture(8'h80, 1'b1, 16, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_read_arm", bus.oBusy, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
